// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Lets two requesters share one combinational ALU. It takes one operation at a
// time, picks a requester round-robin, and drives the winner's operands and
// opcode into the ALU from registers. It holds those registers for EXEC_CYCLES
// cycles, captures the ALU output, and returns it to the owning requester with a
// valid/ready handshake.
//
// Parameters
//   WIDTH        operand/result width (ALU reg_rs1/reg_rs2/alu_out)
//   OPW          opcode width (ALU opcode)
//   EXEC_CYCLES  cycles operands are held before the result is captured, 1..15
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid[1:0]        requester i presents an operation
//   req_ready[1:0]        requester i's operation is accepted this cycle
//   req{0,1}_rs1/rs2      requester operands
//   req{0,1}_opcode       requester opcode
//   resp_valid[1:0]       resp_data holds the result for requester i
//   resp_ready[1:0]       requester i consumes the result
//   resp_data             captured ALU result
//   alu_rs1/rs2/opcode    registered operands/opcode towards the ALU
//   alu_result            combinational ALU output
//   busy                  an operation is executing or waiting to be returned
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int OPW         = 6,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_rs1,
    input  logic [WIDTH-1:0] req0_rs2,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic [WIDTH-1:0] req1_rs1,
    input  logic [WIDTH-1:0] req1_rs2,
    input  logic [OPW-1:0]   req1_opcode,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The counter starts at EXEC_CYCLES-1, so the capture happens after
    // exactly EXEC_CYCLES cycles in EXEC.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [WIDTH-1:0] alu_rs1_q, alu_rs1_d;
    logic [WIDTH-1:0] alu_rs2_q, alu_rs2_d;
    logic [OPW-1:0]   alu_opcode_q, alu_opcode_d;

    logic [1:0]       grant;
    logic             winner;

    // Round-robin pick, offered only in IDLE. On contention the requester
    // that was not served last wins. The pick is gated by rst_n, so req_ready
    // reads 0 while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state_q == ST_IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign winner = grant[1];

    // Next-state logic. Every register holds its value unless the current
    // state explicitly updates it. The alu_* registers therefore stay stable
    // from the grant through the response handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        alu_rs1_d    = alu_rs1_q;
        alu_rs2_d    = alu_rs2_q;
        alu_opcode_d = alu_opcode_q;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    alu_rs1_d    = winner ? req1_rs1    : req0_rs1;
                    alu_rs2_d    = winner ? req1_rs2    : req0_rs2;
                    alu_opcode_d = winner ? req1_opcode : req0_opcode;
                    owner_d      = winner;
                    cnt_d        = CNT_INIT;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    resp_data_d  = alu_result;
                    resp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Only the owner's resp_ready completes the handshake.
                if (resp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    resp_valid_d = 2'b00;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy is registered, so it is derived from the state being entered.
        busy_d = (state_d != ST_IDLE);
    end

    // All state and registered outputs. An asynchronous reset aborts any
    // in-flight operation and discards its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
            resp_data_q  <= '0;
            alu_rs1_q    <= '0;
            alu_rs2_q    <= '0;
            alu_opcode_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            resp_data_q  <= resp_data_d;
            alu_rs1_q    <= alu_rs1_d;
            alu_rs2_q    <= alu_rs2_d;
            alu_opcode_q <= alu_opcode_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign alu_rs1    = alu_rs1_q;
    assign alu_rs2    = alu_rs2_q;
    assign alu_opcode = alu_opcode_q;
    assign busy       = busy_q;

endmodule
